capture_buffer: RTL and testbench
=================================

// Module: capture_buffer
// PURPOSE
//  Trigger-aware sample memory between sampler/trigger_basic and the UART transmit mux.
//  Stores sampler output in a circular RAM while armed and, after the trigger, counts
//  delay_count post-trigger samples. It then streams read_count samples, newest first,
//  as bytes to the UART using the tx_busy handshake.
//  Drives the data branch of the transmit mux.
// PARAMETERS
//  SAMPLE_WIDTH  8   bits per sample; must be 8, 16, 24 or 32
//  DEPTH_LOG2    10  log2 of buffer depth in samples (DEPTH = 2**DEPTH_LOG2)
// PORTS
//  clock        in   1             system clock; all logic rising-edge
//  reset        in   1             asynchronous, active-high; all state cleared
//  arm          in   1             capture enable level; rising edge starts a capture
//  run          in   1             trigger fired (level from trigger_basic)
//  data_in      in   SAMPLE_WIDTH  sample from sampler
//  valid_in     in   1             data_in valid this cycle
//  read_count   in   DEPTH_LOG2+1  samples to transmit; latched on arm rise
//  delay_count  in   DEPTH_LOG2+1  post-trigger samples to store; latched on arm rise
//  tx_busy      in   1             UART transmitter busy
//  tx_data      out  8             byte to transmit
//  tx_start     out  1             1-cycle pulse: UART loads tx_data
//  dump_active  out  1             high in DUMP_* states; selects data branch of tx mux
//  done         out  1             1-cycle pulse when a dump completes
//  state_dbg    out  3             encoded FSM state, for LEDs
// BEHAVIOUR
//  Reset values:
//   - state IDLE; tx_data, tx_start, dump_active, done, wr_ptr, counters all 0.
//   - RAM contents are not cleared.
//  States: IDLE, PRETRIG, POSTTRIG, DUMP_READ, DUMP_SEND, DUMP_WAIT, DONE.
//  IDLE -> PRETRIG on arm rising edge (registered edge detect).
//   - Latch counts, clamp read_count to DEPTH, wr_ptr <= 0.
//  Abort: arm low in any non-IDLE state -> IDLE next cycle; tx_start 0; no done pulse.
//  PRETRIG:
//   - On valid_in, write mem[wr_ptr] <= data_in and increment wr_ptr (wraps mod DEPTH).
//   - run high -> POSTTRIG with post_cnt <= delay_count.
//   - A sample valid in the same cycle as run is written as pre-trigger.
//  POSTTRIG:
//   - post_cnt == 0 -> DUMP_READ; the sample in that cycle is not written.
//   - Otherwise, on valid_in: write, increment wr_ptr, decrement post_cnt.
//   - run is ignored here.
//  Dump entry:
//   - rd_ptr <= wr_ptr-1 (mod DEPTH), remaining <= read_count.
//   - If remaining == 0, go straight to DONE.
//  DUMP_READ: 1-cycle synchronous RAM read latency; word registered into a shift register.
//  DUMP_SEND: wait until tx_busy == 0, then:
//   - tx_data <= low byte of the word; pulse tx_start for 1 cycle.
//   - Go to DUMP_WAIT.
//  DUMP_WAIT:
//   - Ignore tx_busy in the first cycle (guard); then wait for tx_busy == 0.
//   - Then shift the word right 8 bits and send the next byte.
//   - After SAMPLE_WIDTH/8 bytes: decrement remaining and rd_ptr (wraps).
//   - If remaining != 0 -> DUMP_READ; else -> DONE.
//  Byte order: LSB byte first within a sample; samples newest to oldest.
//  Dump length is exactly read_count samples, even if fewer were written.
//   - Unwritten locations return stale RAM data.
//  DONE: done = 1 for 1 cycle -> IDLE. A new capture needs arm to drop and rise again.
//  Only one tx_start is issued per byte; tx_start is never high while tx_busy is high.
// TESTING
//  1 DEPTH_LOG2=4:
//     - Stimulus: arm with delay=3, read=5; samples 0..5 valid, run with sample 5; then 6,7,8.
//     - Required: bytes 8,7,6,5,4 then done pulse.
//  2 Wrap:
//     - Stimulus: DEPTH 16; samples 0..19 pre-trigger, run, delay=0, read=16.
//     - Required: bytes 19 down to 4.
//  3 Clamp and zero count:
//     - read=20 with DEPTH 16 -> exactly 16 bytes.
//     - read=0 -> done 2 cycles after trigger handling, no tx_start.
//  4 Handshake:
//     - Stimulus: SAMPLE_WIDTH=16, sample 0xA55A, tx_busy held 50 cycles per byte.
//     - Required: 0x5A then 0xA5, one tx_start each, none while busy.
//  5 Abort:
//     - Stimulus: drop arm in POSTTRIG, and separately mid-DUMP_WAIT.
//     - Required: IDLE next cycle, dump_active 0, no done pulse.
//  6 Async reset:
//     - Stimulus: assert reset mid-dump, between clock edges.
//     - Required: all outputs 0 immediately; re-arm works normally.

Source files
------------

// File: rtl/capture_buffer_if.sv
// Sampler/trigger inputs and UART transmit-side outputs of capture_buffer.
// Parameters must match the capture_buffer instance the interface is bound to.
interface capture_buffer_if #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int DEPTH_LOG2   = 10
);
  logic                    arm;
  logic                    run;
  logic [SAMPLE_WIDTH-1:0] data_in;
  logic                    valid_in;
  logic [DEPTH_LOG2:0]     read_count;
  logic [DEPTH_LOG2:0]     delay_count;
  logic                    tx_busy;
  logic [7:0]              tx_data;
  logic                    tx_start;
  logic                    dump_active;
  logic                    done;
  logic [2:0]              state_dbg;

  modport master (
    output arm, run, data_in, valid_in, read_count, delay_count, tx_busy,
    input  tx_data, tx_start, dump_active, done, state_dbg
  );
  modport slave (
    input  arm, run, data_in, valid_in, read_count, delay_count, tx_busy,
    output tx_data, tx_start, dump_active, done, state_dbg
  );
endinterface

// File: rtl/capture_buffer.sv
// Trigger-aware circular sample buffer; after the post-trigger window it streams
// read_count samples newest-first, LSB byte first, to the UART via tx_busy handshake.
module capture_buffer #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int DEPTH_LOG2   = 10
) (
  input  logic            clock,
  input  logic            reset,
  capture_buffer_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int NBYTES = SAMPLE_WIDTH / 8;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [1:0] BYTE_LAST = 2'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, PRETRIG = 3'd1, POSTTRIG = 3'd2, DUMP_READ = 3'd3,
    DUMP_SEND = 3'd4, DUMP_WAIT = 3'd5, DONE = 3'd6
  } state_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  state_t state_q, state_d;
  logic   arm_q;
  ptr_t   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t   rd_cnt_q, rd_cnt_d, delay_q, delay_d;
  cnt_t   post_cnt_q, post_cnt_d, remaining_q, remaining_d;
  logic [1:0] byte_cnt_q, byte_cnt_d;
  logic   guard_q, guard_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic   tx_start_q, tx_start_d;
  logic   we, load_word, shift_word;

  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
  logic [SAMPLE_WIDTH-1:0] word_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_cnt_d    = rd_cnt_q;
    delay_d     = delay_q;
    post_cnt_d  = post_cnt_q;
    remaining_d = remaining_q;
    byte_cnt_d  = byte_cnt_q;
    guard_d     = guard_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    we          = 1'b0;
    load_word   = 1'b0;
    shift_word  = 1'b0;
    if (state_q != IDLE && !bus.arm) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (bus.arm && !arm_q) begin
          state_d  = PRETRIG;
          rd_cnt_d = (bus.read_count > DEPTH_CNT) ? DEPTH_CNT : bus.read_count;
          delay_d  = bus.delay_count;
          wr_ptr_d = '0;
        end
        PRETRIG: begin
          // a sample arriving together with run still counts as pre-trigger
          if (bus.valid_in) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
          end
          if (bus.run) begin
            post_cnt_d = delay_q;
            state_d    = POSTTRIG;
          end
        end
        POSTTRIG: begin
          if (post_cnt_q == '0) begin
            rd_ptr_d    = wr_ptr_q - ptr_t'(1);
            remaining_d = rd_cnt_q;
            state_d     = (rd_cnt_q == '0) ? DONE : DUMP_READ;
          end else if (bus.valid_in) begin
            we         = 1'b1;
            wr_ptr_d   = wr_ptr_q + ptr_t'(1);
            post_cnt_d = post_cnt_q - cnt_t'(1);
          end
        end
        DUMP_READ: begin
          load_word  = 1'b1;
          byte_cnt_d = '0;
          state_d    = DUMP_SEND;
        end
        DUMP_SEND: if (!bus.tx_busy) begin
          tx_data_d  = word_q[7:0];
          tx_start_d = 1'b1;
          guard_d    = 1'b1;
          state_d    = DUMP_WAIT;
        end
        DUMP_WAIT: begin
          // the UART raises tx_busy one cycle after tx_start, so skip that cycle
          if (guard_q) begin
            guard_d = 1'b0;
          end else if (!bus.tx_busy) begin
            if (byte_cnt_q == BYTE_LAST) begin
              remaining_d = remaining_q - cnt_t'(1);
              rd_ptr_d    = rd_ptr_q - ptr_t'(1);
              state_d     = (remaining_q == cnt_t'(1)) ? DONE : DUMP_READ;
            end else begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              shift_word = 1'b1;
              state_d    = DUMP_SEND;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      arm_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_cnt_q    <= '0;
      delay_q     <= '0;
      post_cnt_q  <= '0;
      remaining_q <= '0;
      byte_cnt_q  <= '0;
      guard_q     <= 1'b0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_q       <= bus.arm;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_cnt_q    <= rd_cnt_d;
      delay_q     <= delay_d;
      post_cnt_q  <= post_cnt_d;
      remaining_q <= remaining_d;
      byte_cnt_q  <= byte_cnt_d;
      guard_q     <= guard_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
    end
  end

  // RAM and its read/shift register carry no reset so they map onto block RAM
  always_ff @(posedge clock) begin
    if (we) mem[wr_ptr_q] <= bus.data_in;
    if (load_word)       word_q <= mem[rd_ptr_q];
    else if (shift_word) word_q <= word_q >> 8;
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.done        = (state_q == DONE);
  assign bus.dump_active = (state_q == DUMP_READ) || (state_q == DUMP_SEND) ||
                           (state_q == DUMP_WAIT);
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_capture_buffer.sv
// Scoreboard bench: stimulus pushes expected bytes (-1 = done pulse), monitors pop.
module tb_capture_buffer;
  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  capture_buffer_if #(.SAMPLE_WIDTH(8),  .DEPTH_LOG2(4)) b8 ();
  capture_buffer_if #(.SAMPLE_WIDTH(16), .DEPTH_LOG2(4)) b16 ();

  capture_buffer #(.SAMPLE_WIDTH(8),  .DEPTH_LOG2(4)) dut8  (.clock(clock), .reset(rst), .bus(b8));
  capture_buffer #(.SAMPLE_WIDTH(16), .DEPTH_LOG2(4)) dut16 (.clock(clock), .reset(rst), .bus(b16));

  int checks = 0;
  int fails  = 0;
  int q8[$];
  int q16[$];
  int bc8 = 0;
  int bc16 = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // UART models: busy for a fixed number of cycles after each tx_start
  always @(posedge clock or posedge rst)
    if (rst) bc8 <= 0;
    else if (b8.tx_start) bc8 <= 3;
    else if (bc8 > 0) bc8 <= bc8 - 1;
  always @(posedge clock or posedge rst)
    if (rst) bc16 <= 0;
    else if (b16.tx_start) bc16 <= 50;
    else if (bc16 > 0) bc16 <= bc16 - 1;
  assign b8.tx_busy  = (bc8 != 0);
  assign b16.tx_busy = (bc16 != 0);

  always @(negedge clock) if (!rst) begin
    if (b8.tx_start) begin
      chk("start_while_busy8", int'(b8.tx_busy), 0);
      if (q8.size() == 0) chk("unexpected_byte8", int'(b8.tx_data), -2);
      else chk("byte8", int'(b8.tx_data), q8.pop_front());
    end
    if (b8.done) begin
      if (q8.size() == 0) chk("unexpected_done8", 1, 0);
      else chk("done8", -1, q8.pop_front());
    end
  end

  always @(negedge clock) if (!rst) begin
    if (b16.tx_start) begin
      chk("start_while_busy16", int'(b16.tx_busy), 0);
      if (q16.size() == 0) chk("unexpected_byte16", int'(b16.tx_data), -2);
      else chk("byte16", int'(b16.tx_data), q16.pop_front());
    end
    if (b16.done) begin
      if (q16.size() == 0) chk("unexpected_done16", 1, 0);
      else chk("done16", -1, q16.pop_front());
    end
  end

  task automatic arm8(input int rd, input int dl);
    @(posedge clock); #1;
    b8.arm = 1'b0; b8.valid_in = 1'b0; b8.run = 1'b0;
    @(posedge clock); #1;
    b8.read_count = 5'(rd); b8.delay_count = 5'(dl); b8.arm = 1'b1;
  endtask

  task automatic sample8(input int d, input logic r);
    @(posedge clock); #1;
    b8.data_in = 8'(d); b8.valid_in = 1'b1; b8.run = r;
  endtask

  task automatic idle8();
    @(posedge clock); #1;
    b8.valid_in = 1'b0; b8.run = 1'b0;
  endtask

  task automatic drain8(input string name, input int budget);
    int n = 0;
    while (q8.size() != 0 && n < budget) begin @(posedge clock); n++; end
    chk(name, q8.size(), 0);
  endtask

  task automatic wait_state8(input int st, input int budget);
    int n = 0;
    while (int'(b8.state_dbg) != st && n < budget) begin @(posedge clock); #1; n++; end
    chk("reach_state8", int'(b8.state_dbg), st);
  endtask

  initial begin
    b8.arm = 0; b8.run = 0; b8.data_in = '0; b8.valid_in = 0;
    b8.read_count = '0; b8.delay_count = '0;
    b16.arm = 0; b16.run = 0; b16.data_in = '0; b16.valid_in = 0;
    b16.read_count = '0; b16.delay_count = '0;
    repeat (2) @(negedge clock);
    chk("rst_tx_data",   int'(b8.tx_data), 0);
    chk("rst_tx_start",  int'(b8.tx_start), 0);
    chk("rst_dump",      int'(b8.dump_active), 0);
    chk("rst_done",      int'(b8.done), 0);
    chk("rst_state",     int'(b8.state_dbg), 0);
    chk("rst_state16",   int'(b16.state_dbg), 0);
    rst = 1'b0;

    // delay 3, read 5: trigger with sample 5, three post-trigger samples
    arm8(5, 3);
    for (int i = 0; i < 9; i++) sample8(i, i >= 5);
    q8.push_back(8); q8.push_back(7); q8.push_back(6); q8.push_back(5);
    q8.push_back(4); q8.push_back(-1);
    idle8();
    drain8("drain_basic", 200);

    // wrap: 20 samples into a 16-deep buffer
    arm8(16, 0);
    for (int i = 0; i < 20; i++) sample8(i, 1'b0);
    @(posedge clock); #1; b8.valid_in = 1'b0; b8.run = 1'b1;
    for (int i = 19; i >= 4; i--) q8.push_back(i);
    q8.push_back(-1);
    idle8();
    drain8("drain_wrap", 400);

    // read_count 20 clamps to 16
    arm8(20, 0);
    for (int i = 0; i < 16; i++) sample8(100 + i, i == 15);
    for (int i = 115; i >= 100; i--) q8.push_back(i);
    q8.push_back(-1);
    idle8();
    drain8("drain_clamp", 400);
    repeat (10) @(posedge clock);
    chk("clamp_no_extra", q8.size(), 0);

    // read_count 0: done two cycles after the trigger edge, no bytes
    arm8(0, 0);
    sample8(1, 1'b1);
    q8.push_back(-1);
    idle8();
    @(posedge clock); #1;
    chk("zero_done_timing", int'(b8.done), 1);
    drain8("drain_zero", 20);

    // abort in POSTTRIG
    arm8(5, 10);
    sample8(1, 1'b0);
    sample8(2, 1'b1);
    idle8();
    chk("in_posttrig", int'(b8.state_dbg), 2);
    b8.arm = 1'b0;
    @(posedge clock); #1;
    chk("abort_post_state", int'(b8.state_dbg), 0);
    chk("abort_post_dump",  int'(b8.dump_active), 0);
    repeat (10) @(posedge clock);

    // abort in DUMP_WAIT after the first byte
    arm8(4, 0);
    sample8(10, 1'b0);
    sample8(11, 1'b1);
    q8.push_back(11);
    idle8();
    wait_state8(5, 50);
    b8.arm = 1'b0;
    @(posedge clock); #1;
    chk("abort_wait_state", int'(b8.state_dbg), 0);
    chk("abort_wait_dump",  int'(b8.dump_active), 0);
    repeat (20) @(posedge clock);
    chk("abort_wait_queue", q8.size(), 0);

    // 16-bit handshake with a slow UART
    @(posedge clock); #1;
    b16.read_count = 5'd1; b16.delay_count = 5'd0; b16.arm = 1'b1;
    @(posedge clock); #1;
    b16.data_in = 16'hA55A; b16.valid_in = 1'b1; b16.run = 1'b1;
    q16.push_back(8'h5A); q16.push_back(8'hA5); q16.push_back(-1);
    @(posedge clock); #1;
    b16.valid_in = 1'b0; b16.run = 1'b0;
    for (int n = 0; n < 600 && q16.size() != 0; n++) @(posedge clock);
    chk("drain_hs16", q16.size(), 0);
    b16.arm = 1'b0;

    // asynchronous reset between edges mid-dump, then re-arm
    arm8(4, 0);
    for (int i = 20; i < 24; i++) sample8(i, i == 23);
    q8.push_back(23);
    idle8();
    wait_state8(5, 50);
    @(negedge clock); #2;
    rst = 1'b1;
    #1;
    chk("arst_tx_data",  int'(b8.tx_data), 0);
    chk("arst_tx_start", int'(b8.tx_start), 0);
    chk("arst_dump",     int'(b8.dump_active), 0);
    chk("arst_done",     int'(b8.done), 0);
    chk("arst_state",    int'(b8.state_dbg), 0);
    chk("arst_queue",    q8.size(), 0);
    @(posedge clock); #1;
    rst = 1'b0;
    arm8(2, 0);
    sample8(30, 1'b0);
    sample8(31, 1'b1);
    q8.push_back(31); q8.push_back(30); q8.push_back(-1);
    idle8();
    drain8("drain_rearm", 200);
    b8.arm = 1'b0;
    repeat (5) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
